// File: rtl/gon_y_multicast_scheduler.sv
// GON Y-bus column sequencer: shifts row IDs into the multicast-controller scan
// chain, then queues multicast requests and issues them on the Y bus one at a time.
module gon_y_multicast_scheduler #(
  parameter int NUM_ROWS   = 12,
  parameter int ROW_LEN    = 4,
  parameter int ID_LEN     = 5,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_start,
  input  logic                 i_cfg_id_valid,
  output logic                 o_cfg_id_ready,
  input  logic [ROW_LEN-1:0]   i_cfg_id_data,
  output logic                 o_cfg_done,
  output logic                 o_set_id,
  output logic [ROW_LEN-1:0]   o_id_out,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [ROW_LEN-1:0]   i_req_tag,
  input  logic [ID_LEN-1:0]    i_req_tag_id,
  input  logic [VALUE_LEN-1:0] i_req_value,
  output logic [ROW_LEN-1:0]   o_gon_tag,
  output logic [ID_LEN-1:0]    o_gon_tag_id,
  output logic [VALUE_LEN-1:0] o_gon_value,
  output logic                 o_gon_enable,
  input  logic                 i_gon_ready,
  output logic                 o_busy,
  output logic [15:0]          o_xfer_cnt,
  output logic                 o_err_timeout
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SHIFT_W = $clog2(NUM_ROWS + 1);
  localparam int STALL_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CFG   = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ROW_LEN-1:0]   tag;
    logic [ID_LEN-1:0]    tag_id;
    logic [VALUE_LEN-1:0] value;
  } req_t;

  state_t               r_state;
  logic [SHIFT_W-1:0]   r_shift_cnt;
  logic                 r_cfg_done;

  req_t                 r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [15:0]          r_xfer_cnt;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 r_err;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_shift;
  logic                 w_stall;
  logic                 w_cfg_accept;
  req_t                 w_req_in;
  req_t                 w_head;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push       = i_req_valid & ~w_full;
  assign w_issue      = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_shift      = (r_state == S_CFG) & i_cfg_id_valid;
  assign w_cfg_accept = i_cfg_start & ((r_state == S_IDLE) | (r_state == S_RUN));
  assign w_req_in     = '{tag: i_req_tag, tag_id: i_req_tag_id, value: i_req_value};
  assign w_head       = r_mem[r_rd_ptr];

  assign o_gon_enable = w_issue & ~w_empty;
  assign w_pop        = o_gon_enable & i_gon_ready;
  assign w_stall      = o_gon_enable & ~i_gon_ready;

  // Bus fields are forced to zero whenever nothing is offered.
  assign o_gon_tag    = o_gon_enable ? w_head.tag    : '0;
  assign o_gon_tag_id = o_gon_enable ? w_head.tag_id : '0;
  assign o_gon_value  = o_gon_enable ? w_head.value  : '0;

  assign o_set_id       = w_shift;
  assign o_id_out       = w_shift ? i_cfg_id_data : '0;
  assign o_cfg_id_ready = (r_state == S_CFG);
  assign o_cfg_done     = r_cfg_done;
  assign o_req_ready    = ~w_full;
  assign o_busy         = (r_state != S_RUN) | ~w_empty;
  assign o_xfer_cnt     = r_xfer_cnt;
  assign o_err_timeout  = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_start) begin
            r_state     <= S_CFG;
            r_shift_cnt <= '0;
          end
        end
        S_CFG: begin
          if (w_shift) begin
            if (r_shift_cnt == SHIFT_W'(NUM_ROWS - 1)) begin
              r_state     <= S_RUN;
              r_cfg_done  <= 1'b1;
              r_shift_cnt <= '0;
            end else begin
              r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
            end
          end
        end
        S_RUN: begin
          if (i_cfg_start) begin
            r_state     <= w_empty ? S_CFG : S_DRAIN;
            r_shift_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_CFG;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers and count define
  // validity, and unread entries never reach the bus because the fields are gated.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_req_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      // Saturate so a very long stall cannot wrap back below the threshold.
      if (!w_stall) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != STALL_W'(TIMEOUT)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
      if (w_cfg_accept) begin
        r_err <= 1'b0;
      end else if (w_stall && (r_stall_cnt == STALL_W'(TIMEOUT - 1))) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
